// File: rtl/sprite_pkg.sv
// Shared encodings for the sprite motion engine.
//   dir_e  : per-axis travel direction (DIR_INC moves towards larger coords)
//   mode_e : per-axis edge behaviour (MODE_BOUNCE reflects, MODE_WRAP wraps)
package sprite_pkg;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_BOUNCE = 1'b0,
    MODE_WRAP   = 1'b1
  } mode_e;

endpackage

// File: rtl/sprite_axis.sv
// One axis of sprite motion: position register, direction register, edge
// pulse and the per-tick bounce/wrap step.
//   clk_i, rst_i : clock, asynchronous active-high reset (loads first_i)
//   load_i       : synchronous reload of first_i, direction cleared
//   step_i       : advance one step (frame_tick & enable)
//   wrap_i       : 0 = bounce, 1 = wrap
//   first_i      : start position
//   size_i       : sprite extent minus 1
//   del_i        : unsigned step magnitude
//   pos_o, dir_o : registered origin and direction
//   edge_o       : one-cycle pulse on wall contact or wrap
module sprite_axis
  import sprite_pkg::*;
#(
  parameter int RES     = 800,
  parameter int COORD_W = 11,
  parameter int SIZE_W  = 9,
  parameter int DEL_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               wrap_i,
  input  logic [COORD_W-1:0] first_i,
  input  logic [SIZE_W-1:0]  size_i,
  input  logic [DEL_W-1:0]   del_i,
  output logic [COORD_W-1:0] pos_o,
  output logic               dir_o,
  output logic               edge_o
);

  // Two guard bits so sums neither overflow nor lose their sign before
  // being compared against the walls.
  localparam int SW = COORD_W + 2;
  typedef logic signed [SW-1:0] sum_t;
  typedef logic [COORD_W-1:0]   coord_t;

  localparam sum_t MAX_S  = sum_t'(RES - 1);
  localparam sum_t RES_S  = sum_t'(RES);
  localparam sum_t ZERO_S = sum_t'(0);

  coord_t pos_q, pos_d;
  dir_e   dir_q, dir_d;
  logic   edge_q, edge_d;

  sum_t  pos_s, del_s, size_s, fwd_s, back_s, nxt_s;
  mode_e mode;

  assign mode   = mode_e'(wrap_i);
  assign pos_s  = sum_t'(pos_q);
  assign del_s  = sum_t'(del_i);
  assign size_s = sum_t'(size_i);
  assign fwd_s  = pos_s + del_s;
  assign back_s = pos_s - del_s;

  always_comb begin
    nxt_s  = pos_s;
    dir_d  = dir_q;
    edge_d = 1'b0;
    if (step_i) begin
      if (mode == MODE_BOUNCE) begin
        if (size_s >= MAX_S) begin
          // Sprite cannot fit between the walls: park it at the origin.
          nxt_s = ZERO_S;
        end else if (dir_q == DIR_INC) begin
          if (fwd_s + size_s >= MAX_S) begin
            nxt_s  = MAX_S - size_s;
            dir_d  = DIR_DEC;
            edge_d = 1'b1;
          end else begin
            nxt_s = fwd_s;
          end
        end else begin
          if (back_s <= ZERO_S) begin
            nxt_s  = ZERO_S;
            dir_d  = DIR_INC;
            edge_d = 1'b1;
          end else begin
            nxt_s = back_s;
          end
        end
      end else begin
        if (dir_q == DIR_INC) begin
          if (fwd_s > MAX_S) begin
            nxt_s  = fwd_s - RES_S;
            edge_d = 1'b1;
          end else begin
            nxt_s = fwd_s;
          end
        end else begin
          if (back_s < ZERO_S) begin
            nxt_s  = back_s + RES_S;
            edge_d = 1'b1;
          end else begin
            nxt_s = back_s;
          end
        end
      end
    end
    pos_d = coord_t'(nxt_s);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_q  <= first_i;
      dir_q  <= DIR_INC;
      edge_q <= 1'b0;
    end else if (load_i) begin
      pos_q  <= first_i;
      dir_q  <= DIR_INC;
      edge_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      edge_q <= edge_d;
    end
  end

  assign pos_o  = pos_q;
  assign dir_o  = dir_q;
  assign edge_o = edge_q;

endmodule

// File: rtl/sprite_mover.sv
// Single rectangular sprite engine: moves once per frame tick with per-axis
// bounce/wrap, and produces a registered pixel hit and colour.
//   clk, reset                : clock, asynchronous active-high reset
//   frame_tick, enable, load  : step strobe, motion enable, position reload
//   first_x/y, x_size/y_size  : start position, extent minus 1
//   del_x/y, wrap_x/y         : step magnitude, per-axis edge mode
//   X, Y                      : current scan coordinate
//   red_in/green_in/blue_in   : sprite colour
//   pos_x/y, dir_x/y, edge_x/y: motion state and wall-contact pulses
//   yes, red/green/blue       : registered hit flag and gated colour
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int H_RES   = 800,
  parameter int V_RES   = 600,
  parameter int COORD_W = 11,
  parameter int SIZE_W  = 9,
  parameter int DEL_W   = 5,
  parameter int COLOR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic               load,
  input  logic [COORD_W-1:0] first_x,
  input  logic [COORD_W-1:0] first_y,
  input  logic [SIZE_W-1:0]  x_size,
  input  logic [SIZE_W-1:0]  y_size,
  input  logic [DEL_W-1:0]   del_x,
  input  logic [DEL_W-1:0]   del_y,
  input  logic               wrap_x,
  input  logic               wrap_y,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic               edge_x,
  output logic               edge_y,
  output logic               yes,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam int HW = COORD_W + 2;
  typedef logic [HW-1:0] wide_t;

  logic step;
  assign step = frame_tick & enable;

  sprite_axis #(
    .RES    (H_RES),
    .COORD_W(COORD_W),
    .SIZE_W (SIZE_W),
    .DEL_W  (DEL_W)
  ) u_axis_x (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (load),
    .step_i (step),
    .wrap_i (wrap_x),
    .first_i(first_x),
    .size_i (x_size),
    .del_i  (del_x),
    .pos_o  (pos_x),
    .dir_o  (dir_x),
    .edge_o (edge_x)
  );

  sprite_axis #(
    .RES    (V_RES),
    .COORD_W(COORD_W),
    .SIZE_W (SIZE_W),
    .DEL_W  (DEL_W)
  ) u_axis_y (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (load),
    .step_i (step),
    .wrap_i (wrap_y),
    .first_i(first_y),
    .size_i (y_size),
    .del_i  (del_y),
    .pos_o  (pos_y),
    .dir_o  (dir_y),
    .edge_o (edge_y)
  );

  // Inclusive rectangle test in widened unsigned arithmetic so pos+size
  // never wraps.
  wide_t px_w, py_w, sx_w, sy_w, x_w, y_w;
  logic  hit_d;

  assign px_w = wide_t'(pos_x);
  assign py_w = wide_t'(pos_y);
  assign sx_w = wide_t'(x_size);
  assign sy_w = wide_t'(y_size);
  assign x_w  = wide_t'(X);
  assign y_w  = wide_t'(Y);

  assign hit_d = (x_w >= px_w) && (x_w <= px_w + sx_w) &&
                 (y_w >= py_w) && (y_w <= py_w + sy_w);

  logic               yes_q;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      yes_q   <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      yes_q   <= hit_d;
      red_q   <= hit_d ? red_in   : '0;
      green_q <= hit_d ? green_in : '0;
      blue_q  <= hit_d ? blue_in  : '0;
    end
  end

  assign yes   = yes_q;
  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

endmodule

// File: tb/tb_sprite_mover.sv
module tb_sprite_mover;

  localparam int HR = 800;
  localparam int VR = 600;
  localparam int CW = 11;
  localparam int SW = 10;
  localparam int DW = 5;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          reset, frame_tick, enable, load, wrap_x, wrap_y;
  logic [CW-1:0] first_x, first_y, X, Y, pos_x, pos_y;
  logic [SW-1:0] x_size, y_size;
  logic [DW-1:0] del_x, del_y;
  logic [KW-1:0] red_in, green_in, blue_in, red, green, blue;
  logic          dir_x, dir_y, edge_x, edge_y, yes;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int mpx, mpy, mdx, mdy, mex, mey, myes, mr, mg, mb;

  always #5 clk = ~clk;

  sprite_mover #(
    .H_RES(HR), .V_RES(VR), .COORD_W(CW), .SIZE_W(SW), .DEL_W(DW), .COLOR_W(KW)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable), .load(load),
    .first_x(first_x), .first_y(first_y), .x_size(x_size), .y_size(y_size),
    .del_x(del_x), .del_y(del_y), .wrap_x(wrap_x), .wrap_y(wrap_y),
    .X(X), .Y(Y), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .pos_x(pos_x), .pos_y(pos_y), .dir_x(dir_x), .dir_y(dir_y),
    .edge_x(edge_x), .edge_y(edge_y), .yes(yes),
    .red(red), .green(green), .blue(blue)
  );

  // One tick of one axis, straight from the movement rules.
  function automatic void axis_step(input int res, input int wrap, input int pos,
                                    input int del, input int size, input int dir,
                                    output int npos, output int ndir, output int nedge);
    int mx;
    mx = res - 1;
    npos = pos; ndir = dir; nedge = 0;
    if (wrap == 0) begin
      if (size >= mx) npos = 0;
      else if (dir == 0) begin
        if (pos + del + size >= mx) begin npos = mx - size; ndir = 1; nedge = 1; end
        else npos = pos + del;
      end else begin
        if (pos - del <= 0) begin npos = 0; ndir = 0; nedge = 1; end
        else npos = pos - del;
      end
    end else begin
      if (dir == 0) begin
        if (pos + del > mx) begin npos = pos + del - res; nedge = 1; end
        else npos = pos + del;
      end else begin
        if (pos - del < 0) begin npos = pos - del + res; nedge = 1; end
        else npos = pos - del;
      end
    end
  endfunction

  // Advance one clock with current inputs, updating the model alongside.
  task automatic cycle();
    int npx, npy, ndx, ndy, nex, ney, hit;
    npx = mpx; npy = mpy; ndx = mdx; ndy = mdy; nex = 0; ney = 0;
    if (load) begin
      npx = int'(first_x); npy = int'(first_y); ndx = 0; ndy = 0;
    end else if (frame_tick && enable) begin
      axis_step(HR, int'(wrap_x), mpx, int'(del_x), int'(x_size), mdx, npx, ndx, nex);
      axis_step(VR, int'(wrap_y), mpy, int'(del_y), int'(y_size), mdy, npy, ndy, ney);
    end
    hit = (int'(X) >= mpx && int'(X) <= mpx + int'(x_size) &&
           int'(Y) >= mpy && int'(Y) <= mpy + int'(y_size)) ? 1 : 0;
    @(posedge clk);
    #1;
    mpx = npx; mpy = npy; mdx = ndx; mdy = ndy; mex = nex; mey = ney;
    myes = hit;
    mr = hit ? int'(red_in) : 0;
    mg = hit ? int'(green_in) : 0;
    mb = hit ? int'(blue_in) : 0;
  endtask

  task automatic model_reset();
    mpx = int'(first_x); mpy = int'(first_y);
    mdx = 0; mdy = 0; mex = 0; mey = 0; myes = 0; mr = 0; mg = 0; mb = 0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
  endtask

  task automatic do_load(input int fx, input int fy);
    first_x = CW'(fx); first_y = CW'(fy);
    load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  task automatic test_reset();
    first_x = 11'd100; first_y = 11'd50;
    reset = 1'b1;
    #12;
    checks++;
    if (pos_x !== 11'd100 || pos_y !== 11'd50 || dir_x !== 1'b0 || dir_y !== 1'b0 ||
        yes !== 1'b0 || {red, green, blue} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: pos=(%0d,%0d) dir=(%b,%b) yes=%b rgb=%h expected pos=(100,50) dir=0 yes=0 rgb=0",
               pos_x, pos_y, dir_x, dir_y, yes, {red, green, blue});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    // Load with a coincident frame tick: the tick must be ignored.
    first_x = 11'd10; first_y = 11'd20; del_x = 5'd7; del_y = 5'd7;
    load = 1'b1; frame_tick = 1'b1;
    cycle();
    load = 1'b0; frame_tick = 1'b0;
    checks++;
    if (pos_x !== 11'd10 || pos_y !== 11'd20 || edge_x !== 1'b0) begin
      errors++;
      $display("FAIL load_over_tick: pos=(%0d,%0d) edge_x=%b expected (10,20) edge_x=0", pos_x, pos_y, edge_x);
    end
  endtask

  task automatic test_bounce_right();
    wrap_x = 1'b0; x_size = 10'd15; del_x = 5'd8; y_size = 10'd5; del_y = 5'd0;
    do_load(780, 20);
    tick();
    checks++;
    if (pos_x !== 11'd784 || dir_x !== 1'b1 || edge_x !== 1'b1) begin
      errors++;
      $display("FAIL bounce_right_hit: pos_x=%0d dir_x=%b edge_x=%b expected 784 1 1", pos_x, dir_x, edge_x);
    end
    cycle();
    checks++;
    if (edge_x !== 1'b0 || pos_x !== 11'd784) begin
      errors++;
      $display("FAIL bounce_right_pulse: edge_x=%b pos_x=%0d expected 0 784", edge_x, pos_x);
    end
    tick();
    checks++;
    if (pos_x !== 11'd776 || edge_x !== 1'b0 || dir_x !== 1'b1) begin
      errors++;
      $display("FAIL bounce_right_next: pos_x=%0d edge_x=%b dir_x=%b expected 776 0 1", pos_x, edge_x, dir_x);
    end
  endtask

  task automatic test_bounce_left();
    // 0+5+796 reaches the right wall, placing the sprite at 3 heading left.
    wrap_x = 1'b0; x_size = 10'd796; del_x = 5'd5;
    do_load(0, 20);
    tick();
    checks++;
    if (pos_x !== 11'd3 || dir_x !== 1'b1 || edge_x !== 1'b1) begin
      errors++;
      $display("FAIL bounce_setup: pos_x=%0d dir_x=%b edge_x=%b expected 3 1 1", pos_x, dir_x, edge_x);
    end
    x_size = 10'd15;
    enable = 1'b0;
    tick();
    checks++;
    if (pos_x !== 11'd3 || dir_x !== 1'b1 || edge_x !== 1'b0) begin
      errors++;
      $display("FAIL enable_low: pos_x=%0d dir_x=%b edge_x=%b expected 3 1 0", pos_x, dir_x, edge_x);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (pos_x !== 11'd0 || dir_x !== 1'b0 || edge_x !== 1'b1) begin
      errors++;
      $display("FAIL bounce_left: pos_x=%0d dir_x=%b edge_x=%b expected 0 0 1", pos_x, dir_x, edge_x);
    end
  endtask

  task automatic test_wrap();
    wrap_x = 1'b1; x_size = 10'd15; del_x = 5'd10;
    do_load(795, 20);
    tick();
    checks++;
    if (pos_x !== 11'd5 || edge_x !== 1'b1 || dir_x !== 1'b0) begin
      errors++;
      $display("FAIL wrap_right: pos_x=%0d edge_x=%b dir_x=%b expected 5 1 0", pos_x, edge_x, dir_x);
    end
    // Bounce into position 2 heading left, then switch to wrap.
    wrap_x = 1'b0; x_size = 10'd797; del_x = 5'd4;
    do_load(0, 20);
    tick();
    wrap_x = 1'b1;
    tick();
    checks++;
    if (pos_x !== 11'd798 || edge_x !== 1'b1 || dir_x !== 1'b1) begin
      errors++;
      $display("FAIL wrap_left: pos_x=%0d edge_x=%b dir_x=%b expected 798 1 1", pos_x, edge_x, dir_x);
    end
  endtask

  task automatic test_y_and_hit();
    wrap_x = 1'b0; wrap_y = 1'b0; x_size = 10'd15; y_size = 10'd9;
    del_x = 5'd0; del_y = 5'd1;
    do_load(100, 590);
    tick();
    checks++;
    if (pos_y !== 11'd590 || dir_y !== 1'b1 || edge_y !== 1'b1 || pos_x !== 11'd100) begin
      errors++;
      $display("FAIL bounce_y: pos=(%0d,%0d) dir_y=%b edge_y=%b expected (100,590) 1 1", pos_x, pos_y, dir_y, edge_y);
    end
    X = 11'd100; Y = 11'd599; red_in = 4'hA; green_in = 4'h5; blue_in = 4'hC;
    cycle();
    checks++;
    if (yes !== 1'b1 || {red, green, blue} !== 12'hA5C) begin
      errors++;
      $display("FAIL hit_corner: yes=%b rgb=%h expected 1 a5c", yes, {red, green, blue});
    end
    Y = 11'd600;
    cycle();
    checks++;
    if (yes !== 1'b0 || {red, green, blue} !== 12'h000) begin
      errors++;
      $display("FAIL hit_below: yes=%b rgb=%h expected 0 000", yes, {red, green, blue});
    end
  endtask

  task automatic test_oversize();
    wrap_x = 1'b0; x_size = 10'd800; del_x = 5'd3;
    do_load(50, 20);
    tick();
    checks++;
    if (pos_x !== 11'd0 || dir_x !== 1'b0 || edge_x !== 1'b0) begin
      errors++;
      $display("FAIL oversize: pos_x=%0d dir_x=%b edge_x=%b expected 0 0 0", pos_x, dir_x, edge_x);
    end
  endtask

  task automatic test_async_reset();
    wrap_x = 1'b0; wrap_y = 1'b0; x_size = 10'd10; y_size = 10'd10;
    del_x = 5'd9; del_y = 5'd6;
    do_load(200, 100);
    X = 11'd205; Y = 11'd105;
    tick(); tick();
    first_x = 11'd333; first_y = 11'd222;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (pos_x !== 11'd333 || pos_y !== 11'd222 || dir_x !== 1'b0 || edge_x !== 1'b0 ||
        yes !== 1'b0 || {red, green, blue} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: pos=(%0d,%0d) dir_x=%b edge_x=%b yes=%b rgb=%h expected (333,222) 0 0 0 000",
               pos_x, pos_y, dir_x, edge_x, yes, {red, green, blue});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    cycle();
    checks++;
    if (pos_x !== 11'd333 || pos_y !== 11'd222) begin
      errors++;
      $display("FAIL post_reset_hold: pos=(%0d,%0d) expected (333,222)", pos_x, pos_y);
    end
    del_x = 5'd7;
    tick();
    checks++;
    if (pos_x !== 11'd340 || pos_y !== 11'd228) begin
      errors++;
      $display("FAIL post_reset_step: pos=(%0d,%0d) expected (340,228)", pos_x, pos_y);
    end
  endtask

  task automatic test_random();
    logic [38:0] act, exp;
    int xr, yr;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        wrap_x = 1'($urandom); wrap_y = 1'($urandom);
        x_size = ($urandom_range(0, 15) == 0) ? SW'($urandom) : SW'($urandom_range(0, 300));
        y_size = ($urandom_range(0, 15) == 0) ? SW'($urandom) : SW'($urandom_range(0, 300));
      end
      load = ($urandom_range(0, 31) == 0);
      first_x = CW'($urandom_range(0, HR - 1));
      first_y = CW'($urandom_range(0, VR - 1));
      frame_tick = ($urandom_range(0, 2) == 0);
      enable = ($urandom_range(0, 4) != 0);
      del_x = DW'($urandom); del_y = DW'($urandom);
      xr = mpx + int'($urandom_range(0, 60)) - 20;
      yr = mpy + int'($urandom_range(0, 60)) - 20;
      X = CW'((xr < 0) ? 0 : xr);
      Y = CW'((yr < 0) ? 0 : yr);
      red_in = KW'($urandom); green_in = KW'($urandom); blue_in = KW'($urandom);
      cycle();
      act = {pos_x, pos_y, dir_x, dir_y, edge_x, edge_y, yes, red, green, blue};
      exp = {CW'(mpx), CW'(mpy), 1'(mdx), 1'(mdy), 1'(mex), 1'(mey), 1'(myes),
             KW'(mr), KW'(mg), KW'(mb)};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %h expected %h", i, act, exp);
      end
    end
    load = 1'b0; frame_tick = 1'b0;
  endtask

  initial begin
    frame_tick = 1'b0; enable = 1'b1; load = 1'b0;
    wrap_x = 1'b0; wrap_y = 1'b0;
    x_size = '0; y_size = '0; del_x = '0; del_y = '0;
    X = '0; Y = '0; red_in = '0; green_in = '0; blue_in = '0;
    first_x = '0; first_y = '0;
    test_reset();
    test_bounce_right();
    test_bounce_left();
    test_wrap();
    test_y_and_hit();
    test_oversize();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
